// File: rtl/banco_registros_param_pkg.sv
// Shared definitions for the banco_registros_param register file:
// encoding of the context save/restore sequencer states.
package paq_banco_registros;

  localparam logic [1:0] COD_REPOSO      = 2'd0;
  localparam logic [1:0] COD_GUARDANDO   = 2'd1;
  localparam logic [1:0] COD_RESTAURANDO = 2'd2;

  typedef enum logic [1:0] {
    REPOSO      = COD_REPOSO,
    GUARDANDO   = COD_GUARDANDO,
    RESTAURANDO = COD_RESTAURANDO
  } estado_t;

endpackage

// File: rtl/banco_registros_param_secuenciador.sv
// Context save/restore sequencer: walks every register index once per request,
// one index per cycle, and pulses o_Listo on the cycle after the last copy.
//
//  state       | meaning
//  REPOSO      | idle, writes and new requests accepted
//  GUARDANDO   | copying reg[cnt] -> shadow[cnt]
//  RESTAURANDO | copying shadow[cnt] -> reg[cnt]
module secuenciador_contexto
  import paq_banco_registros::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              i_Timming,
  input  logic              i_Rst,
  input  logic              i_Guardar,
  input  logic              i_Restaurar,
  output logic              o_Ocupado,
  output logic              o_Listo,
  output logic [ADDR_W-1:0] o_Indice,
  output logic              o_Paso_guardar,
  output logic              o_Paso_restaurar
);

  localparam logic [ADDR_W-1:0] ULTIMO = '1;

  estado_t           estado, estado_sig;
  logic [ADDR_W-1:0] cnt, cnt_sig;
  logic              listo_sig;

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      estado  <= REPOSO;
      cnt     <= '0;
      o_Listo <= 1'b0;
    end else begin
      estado  <= estado_sig;
      cnt     <= cnt_sig;
      o_Listo <= listo_sig;
    end
  end

  // Save has priority when both requests arrive together.
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    listo_sig  = 1'b0;
    case (estado)
      REPOSO: begin
        if (i_Guardar) begin
          estado_sig = GUARDANDO;
          cnt_sig    = '0;
        end else if (i_Restaurar) begin
          estado_sig = RESTAURANDO;
          cnt_sig    = '0;
        end
      end
      GUARDANDO, RESTAURANDO: begin
        cnt_sig = cnt + 1'b1;
        if (cnt == ULTIMO) begin
          estado_sig = REPOSO;
          listo_sig  = 1'b1;
        end
      end
      default: begin
        estado_sig = REPOSO;
        cnt_sig    = '0;
      end
    endcase
  end

  assign o_Ocupado        = (estado != REPOSO);
  assign o_Indice         = cnt;
  assign o_Paso_guardar   = (estado == GUARDANDO);
  assign o_Paso_restaurar = (estado == RESTAURANDO);

endmodule

// File: rtl/banco_registros_param.sv
// General-purpose register file with two registered read ports, read-during-write
// bypass, optional hardwired-zero R0 and a shadow bank for interrupt context switches.
module banco_registros_param
  import paq_banco_registros::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              i_Timming,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] i_Datos,
  input  logic              i_Escritura,
  input  logic [ADDR_W-1:0] i_Sel_escritura,
  input  logic [ADDR_W-1:0] i_Sel_RX,
  input  logic [ADDR_W-1:0] i_Sel_RY,
  input  logic              i_Guardar,
  input  logic              i_Restaurar,
  output logic [DATA_W-1:0] o_RX,
  output logic [DATA_W-1:0] o_RY,
  output logic              o_Ocupado,
  output logic              o_Listo
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];

  logic [ADDR_W-1:0] indice;
  logic              paso_guardar, paso_restaurar;

  secuenciador_contexto #(.ADDR_W(ADDR_W)) u_secuenciador (
    .i_Timming        (i_Timming),
    .i_Rst            (i_Rst),
    .i_Guardar        (i_Guardar),
    .i_Restaurar      (i_Restaurar),
    .o_Ocupado        (o_Ocupado),
    .o_Listo          (o_Listo),
    .o_Indice         (indice),
    .o_Paso_guardar   (paso_guardar),
    .o_Paso_restaurar (paso_restaurar)
  );

  // Single effective write port: external writes only when idle, restore copies otherwise.
  logic              we_eff;
  logic [ADDR_W-1:0] wa_eff;
  logic [DATA_W-1:0] wd_eff;

  always_comb begin
    we_eff = 1'b0;
    wa_eff = i_Sel_escritura;
    wd_eff = i_Datos;
    if (paso_restaurar) begin
      we_eff = !(R0_ZERO && (indice == '0));
      wa_eff = indice;
      wd_eff = shadow[indice];
    end else if (i_Escritura && !o_Ocupado) begin
      we_eff = !(R0_ZERO && (i_Sel_escritura == '0));
    end
  end

  logic [DATA_W-1:0] rx_sig, ry_sig;

  always_comb begin
    rx_sig = regs[i_Sel_RX];
    if (BYPASS && we_eff && (i_Sel_RX == wa_eff)) rx_sig = wd_eff;
    if (R0_ZERO && (i_Sel_RX == '0))             rx_sig = '0;
  end

  always_comb begin
    ry_sig = regs[i_Sel_RY];
    if (BYPASS && we_eff && (i_Sel_RY == wa_eff)) ry_sig = wd_eff;
    if (R0_ZERO && (i_Sel_RY == '0))             ry_sig = '0;
  end

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
      o_RX <= '0;
      o_RY <= '0;
    end else begin
      if (we_eff)       regs[wa_eff]   <= wd_eff;
      if (paso_guardar) shadow[indice] <= regs[indice];
      o_RX <= rx_sig;
      o_RY <= ry_sig;
    end
  end

endmodule
